// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants, types and helpers for the pipeline-stage buffer.
package pipe_stage_buf_pkg;

  // Pass-through mode selectors for the PASS_THRU parameter
  localparam int unsigned PT_OFF = 0;
  localparam int unsigned PT_ON  = 1;

  // Legal buffer depth range
  localparam int unsigned DEPTH_MIN = 1;
  localparam int unsigned DEPTH_MAX = 8;

  // Derived occupancy state of the stage
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_e;

  // True when a depth value is within the supported range
  function automatic bit depth_ok(input int unsigned depth);
    return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
  endfunction

  // Pointer width; a single-entry ring still needs a 1-bit pointer
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_stage_ring.sv
// Circular payload storage with read/write pointers and explicit wrap.
module pipe_stage_ring
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

  // Depth need not be a power of two, so wrap on an explicit compare
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Write the incoming entry at the tail
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
    end
  end

  // Advance pointers; clear returns both to zero without touching storage
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  // Storage and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Head entry straight from registers; never a bypass of wr_data
  assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage handshake controller: buffers entries, drives allow_in
// upstream and valid/data downstream, with flush and a stall counter.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter  int unsigned DATA_W    = 64,
  parameter  int unsigned DEPTH     = 2,
  parameter  int unsigned PASS_THRU = PT_ON,
  parameter  int unsigned STALL_W   = 32,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               allow_in,
  input  logic               ready_go,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               down_allow_in,
  input  logic               flush,
  output logic [CNT_W-1:0]   occupancy,
  output logic [STALL_W-1:0] stall_cnt
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("pipe_stage_buf: DEPTH must be in 1..8");
  end
  if (PASS_THRU != PT_OFF && PASS_THRU != PT_ON) begin : g_bad_pt
    $error("pipe_stage_buf: PASS_THRU must be PT_OFF or PT_ON");
  end

  localparam logic PT_EN = (PASS_THRU == PT_ON);

  logic [CNT_W-1:0]   occ_q, occ_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  occ_state_e         occ_state;
  logic               head_valid;
  logic               full;
  logic               pop_ok;
  logic               push;
  logic               pop;
  logic               stall_inc;

  // Classify occupancy into empty / partial / full
  always_comb begin
    occ_state = OCC_PARTIAL;
    if (occ_q == '0) begin
      occ_state = OCC_EMPTY;
    end else if (occ_q == CNT_W'(DEPTH)) begin
      occ_state = OCC_FULL;
    end
  end

  assign head_valid = (occ_state != OCC_EMPTY);
  assign full       = (occ_state == OCC_FULL);

  // Handshake equations; allow_in sees the raw downstream pop so it is
  // unaffected by flush, and never depends on in_valid
  assign out_valid = head_valid & ready_go;
  assign pop_ok    = out_valid & down_allow_in;
  assign allow_in  = !full | (PT_EN & pop_ok);
  assign push      = in_valid & allow_in & !flush;
  assign pop       = pop_ok & !flush;

  // Occupancy update; flush wins over push and pop
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (push && !pop) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  // Saturating count of cycles the head was held back
  always_comb begin
    stall_inc = head_valid & !(ready_go & down_allow_in) & !flush;
    stall_d   = stall_q;
    if (stall_inc && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q   <= '0;
      stall_q <= '0;
    end else begin
      occ_q   <= occ_d;
      stall_q <= stall_d;
    end
  end

  assign occupancy = occ_q;
  assign stall_cnt = stall_q;

  pipe_stage_ring #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .wr_en   (push),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (out_data)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop));

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf across three configurations.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic        ready_go;
  logic        dai;
  logic        flush;

  // Instance A: DEPTH=2, pass-through
  logic        a_allow, a_ov;
  logic [63:0] a_data;
  logic [1:0]  a_occ;
  logic [31:0] a_stall;
  // Instance B: DEPTH=1, no pass-through
  logic        b_allow, b_ov;
  logic [63:0] b_data;
  logic [0:0]  b_occ;
  logic [31:0] b_stall;
  // Instance C: DEPTH=3, pass-through, 4-bit stall counter
  logic        c_allow, c_ov;
  logic [63:0] c_data;
  logic [1:0]  c_occ;
  logic [3:0]  c_stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(64), .DEPTH(2), .PASS_THRU(1), .STALL_W(32)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .allow_in(a_allow),
    .ready_go(ready_go), .out_valid(a_ov), .out_data(a_data), .down_allow_in(dai),
    .flush(flush), .occupancy(a_occ), .stall_cnt(a_stall));

  pipe_stage_buf #(.DATA_W(64), .DEPTH(1), .PASS_THRU(0), .STALL_W(32)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .allow_in(b_allow),
    .ready_go(ready_go), .out_valid(b_ov), .out_data(b_data), .down_allow_in(dai),
    .flush(flush), .occupancy(b_occ), .stall_cnt(b_stall));

  pipe_stage_buf #(.DATA_W(64), .DEPTH(3), .PASS_THRU(1), .STALL_W(4)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .allow_in(c_allow),
    .ready_go(ready_go), .out_valid(c_ov), .out_data(c_data), .down_allow_in(dai),
    .flush(flush), .occupancy(c_occ), .stall_cnt(c_stall));

  // Single comparison point for every check
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    ready_go = 1'b1;
    dai      = 1'b1;
    flush    = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    #1;
    check_eq("rst_allow", 64'(a_allow), 64'd1);
    check_eq("rst_ov",    64'(a_ov),    64'd0);
    check_eq("rst_data",  a_data,       64'd0);
    check_eq("rst_occ",   64'(a_occ),   64'd0);
    check_eq("rst_stall", 64'(a_stall), 64'd0);

    // 1: streaming, one-cycle latency, allow_in stays high
    for (int k = 1; k <= 6; k++) begin
      in_valid = 1'b1;
      in_data  = 64'(k);
      #1;
      check_eq("t1_allow", 64'(a_allow), 64'd1);
      if (k > 1) begin
        check_eq("t1_ov",   64'(a_ov), 64'd1);
        check_eq("t1_data", a_data,    64'(k - 1));
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    check_eq("t1_last_data", a_data,     64'd6);
    check_eq("t1_occ",       64'(a_occ), 64'd1);
    tick();
    check_eq("t1_drained", 64'(a_ov), 64'd0);

    // 2: backpressure, then pass-through release
    do_reset();
    in_valid = 1'b1; in_data = 64'd10; dai = 1'b1;
    #1;
    check_eq("t2_allow0", 64'(a_allow), 64'd1);
    tick();
    dai = 1'b0; in_data = 64'd11;
    #1;
    check_eq("t2_occ1",   64'(a_occ),   64'd1);
    check_eq("t2_allow1", 64'(a_allow), 64'd1);
    tick();
    in_data = 64'd12;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t2_occ2",      64'(a_occ),   64'd2);
      check_eq("t2_allow_low", 64'(a_allow), 64'd0);
      tick();
    end
    check_eq("t2_stall4", 64'(a_stall), 64'd4);
    dai = 1'b1;
    #1;
    check_eq("t2_pt_allow", 64'(a_allow), 64'd1);
    check_eq("t2_ov",       64'(a_ov),    64'd1);
    check_eq("t2_d10",      a_data,       64'd10);
    tick();
    in_data = 64'd13;
    #1;
    check_eq("t2_d11",       a_data,       64'd11);
    check_eq("t2_pt_allow2", 64'(a_allow), 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    check_eq("t2_d12", a_data, 64'd12);
    tick();
    check_eq("t2_d13", a_data,     64'd13);
    check_eq("t2_ov3", 64'(a_ov),  64'd1);
    tick();
    check_eq("t2_empty",  64'(a_occ),   64'd0);
    check_eq("t2_stallk", 64'(a_stall), 64'd4);

    // 3: DEPTH=1 without pass-through, half throughput
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 64'(i / 2 + 1);
      #1;
      check_eq("t3_allow", 64'(b_allow), 64'(i % 2 == 0));
      check_eq("t3_ov",    64'(b_ov),    64'(i % 2 == 1));
      if (i % 2 == 1) check_eq("t3_data", b_data, 64'((i + 1) / 2));
      tick();
    end
    in_valid = 1'b0;

    // 4: ready_go held low on the head entry
    do_reset();
    ready_go = 1'b0; in_valid = 1'b1; in_data = 64'hA;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t4_ov_low", 64'(a_ov), 64'd0);
      tick();
    end
    ready_go = 1'b1;
    #1;
    check_eq("t4_ov",    64'(a_ov),    64'd1);
    check_eq("t4_data",  a_data,       64'hA);
    check_eq("t4_stall", 64'(a_stall), 64'd3);
    tick();
    check_eq("t4_occ0", 64'(a_occ), 64'd0);

    // 5: flush while full with simultaneous push and pop
    do_reset();
    dai = 1'b0; in_valid = 1'b1; in_data = 64'h21;
    tick();
    in_data = 64'h22;
    tick();
    check_eq("t5_full", 64'(a_occ), 64'd2);
    flush = 1'b1; dai = 1'b1; in_data = 64'h23;
    #1;
    check_eq("t5_ov_pre", 64'(a_ov), 64'd1);
    tick();
    flush = 1'b0; dai = 1'b0; in_data = 64'h24;
    #1;
    check_eq("t5_occ0",  64'(a_occ),   64'd0);
    check_eq("t5_ov0",   64'(a_ov),    64'd0);
    check_eq("t5_stall", 64'(a_stall), 64'd1);
    tick();
    in_valid = 1'b0; flush = 1'b1;
    #1;
    check_eq("t5_occ1", 64'(a_occ), 64'd1);
    check_eq("t5_new",  a_data,     64'h24);
    tick();
    flush = 1'b0;
    check_eq("t5_occ_f2",   64'(a_occ),   64'd0);
    check_eq("t5_stall_f2", 64'(a_stall), 64'd1);

    // 6a: DEPTH=3 ordering across pointer wrap
    do_reset();
    dai = 1'b0; in_valid = 1'b1; in_data = 64'h31;
    tick();
    in_data = 64'h32;
    tick();
    dai = 1'b1;
    for (int k = 3; k <= 7; k++) begin
      in_data = 64'(8'h30 + k);
      #1;
      check_eq("t6_ov",    64'(c_ov),    64'd1);
      check_eq("t6_data",  c_data,       64'(8'h30 + k - 2));
      check_eq("t6_allow", 64'(c_allow), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 6; k <= 7; k++) begin
      #1;
      check_eq("t6_tail", c_data, 64'(8'h30 + k));
      tick();
    end
    check_eq("t6_empty", 64'(c_occ), 64'd0);

    // 6b: 4-bit stall counter saturates at 15
    do_reset();
    dai = 1'b0; in_valid = 1'b1; in_data = 64'h55;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) check_eq("t6_stall14", 64'(c_stall), 64'd14);
    end
    check_eq("t6_sat", 64'(c_stall), 64'd15);

    // 6c: reset while full and mid-handshake
    in_valid = 1'b1; in_data = 64'h56;
    tick();
    in_data = 64'h57;
    tick();
    check_eq("t6_full",       64'(c_occ),   64'd3);
    check_eq("t6_full_allow", 64'(c_allow), 64'd0);
    dai = 1'b1; in_data = 64'h58; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("t6_rst_occ",   64'(c_occ),   64'd0);
    check_eq("t6_rst_ov",    64'(c_ov),    64'd0);
    check_eq("t6_rst_data",  c_data,       64'd0);
    check_eq("t6_rst_allow", 64'(c_allow), 64'd1);
    check_eq("t6_rst_stall", 64'(c_stall), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
